// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer between the load/store port and dmem
// Store-to-load forwarding is built only when STBUF_FWD_EN is defined; otherwise any hit stalls.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            st_valid,
   output logic            st_ready,
   input  logic [31:0]     st_addr,
   input  logic [31:0]     st_data,
   input  logic            st_byte,
   input  logic            ld_req,
   input  logic [31:0]     ld_addr,
   input  logic            ld_byte,
   output logic [31:0]     ld_data,
   output logic            ld_stall,
   output logic            mem_we,
   output logic            mem_be,
   output logic [31:0]     mem_a,
   output logic [31:0]     mem_wd,
   input  logic [31:0]     mem_rd,
   output logic [PTRW:0]   sb_count,
   output logic            sb_empty
);

   logic [31:0]     addr_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic            byte_q [DEPTH];
   logic [PTRW:0]   wr_ptr, rd_ptr, count;
   logic [PTRW-1:0] head, idx;
   logic            full, empty, push, pop, hit, fwd, load_port;
   logic [31:0]     src_word;
   logic [7:0]      lane;
`ifdef STBUF_FWD_EN
   logic [PTRW-1:0] hit_idx;
`endif

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (PTRW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign head     = rd_ptr[PTRW-1:0];
   assign st_ready = !full;
   assign sb_count = count;
   assign sb_empty = empty;
   assign push     = st_valid && !full;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef STBUF_FWD_EN
      hit_idx = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTRW'(k);
         if (((PTRW+1)'(k) < count) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
            hit = 1'b1;
`ifdef STBUF_FWD_EN
            hit_idx = idx;
`endif
         end
      end
   end

`ifdef STBUF_FWD_EN
   assign fwd = hit && (!byte_q[hit_idx] ||
                        (ld_byte && (addr_q[hit_idx][1:0] == ld_addr[1:0])));
   // Byte entries hold their value in [7:0]; move it to its lane so the
   // common lane select below works for both sources.
   assign src_word = !fwd ? mem_rd :
                     byte_q[hit_idx] ? ({24'b0, data_q[hit_idx][7:0]} << {ld_addr[1:0], 3'b000}) :
                     data_q[hit_idx];
`else
   assign fwd      = 1'b0;
   assign src_word = mem_rd;
`endif

   assign ld_stall  = ld_req && hit && !fwd;
   assign load_port = ld_req && !hit;
   assign pop       = !load_port && !empty;

   always_comb begin
      case (ld_addr[1:0])
         2'd0:    lane = src_word[7:0];
         2'd1:    lane = src_word[15:8];
         2'd2:    lane = src_word[23:16];
         default: lane = src_word[31:24];
      endcase
      ld_data = ld_byte ? {24'b0, lane} : src_word;
   end

   always_comb begin
      mem_we = 1'b0;
      mem_be = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (load_port) begin
         mem_a  = ld_addr;
         mem_be = ld_byte;
      end else if (!empty) begin
         mem_we = 1'b1;
         mem_a  = addr_q[head];
         mem_wd = data_q[head];
         mem_be = byte_q[head];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (PTRW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (PTRW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr[PTRW-1:0]] <= st_addr;
         data_q[wr_ptr[PTRW-1:0]] <= st_data;
         byte_q[wr_ptr[PTRW-1:0]] <= st_byte;
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed self-checking bench for dmem_store_buffer
// Expectations for forwarding cases follow STBUF_FWD_EN.
module tb_dmem_store_buffer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        st_valid, st_ready, st_byte;
   logic [31:0] st_addr, st_data;
   logic        ld_req, ld_byte, ld_stall;
   logic [31:0] ld_addr, ld_data;
   logic        mem_we, mem_be;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic [2:0]  sb_count;
   logic        sb_empty;

   logic [31:0] dmem [256];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   dmem_store_buffer #(.DEPTH(4), .PTRW(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_byte(st_byte),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_byte(ld_byte),
      .ld_data(ld_data), .ld_stall(ld_stall),
      .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_rd(mem_rd), .sb_count(sb_count), .sb_empty(sb_empty)
   );

   assign mem_rd = dmem[mem_a[9:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_be)
            dmem[mem_a[9:2]][{mem_a[1:0], 3'b000} +: 8] = mem_wd[7:0];
         else
            dmem[mem_a[9:2]] = mem_wd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         dmem[i] = {16'hC0DE, 16'(i)};
      st_valid = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0;
      ld_req = 1'b0; ld_byte = 1'b0; ld_addr = '0;
      #3;
      chk("rst_count", 32'(sb_count), 32'd0);
      chk("rst_empty", 32'(sb_empty), 32'd1);
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(ld_stall), 32'd0);
      chk("rst_a", mem_a, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      // back-to-back word stores retire in order one cycle after push
      st_valid = 1'b1; st_byte = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            st_addr = 32'h10 + 32'(4 * k);
            st_data = 32'hA0 + 32'(k);
         end else begin
            st_valid = 1'b0;
         end
         #1;
         if (k == 0) begin
            chk("t1_idle_we", 32'(mem_we), 32'd0);
         end else begin
            chk("t1_we", 32'(mem_we), 32'd1);
            chk("t1_a", mem_a, 32'h10 + 32'(4 * (k - 1)));
            chk("t1_wd", mem_wd, 32'hA0 + 32'(k - 1));
            chk("t1_cnt", 32'(sb_count), 32'd1);
         end
         tick();
      end
      chk("t1_empty", 32'(sb_empty), 32'd1);
      chk("t1_we_off", 32'(mem_we), 32'd0);
      chk("t1_mem10", dmem[4], 32'hA0);
      chk("t1_mem1c", dmem[7], 32'hA3);

      // fill behind a stream of unrelated loads, then hold a store while full
      ld_req = 1'b1; ld_addr = 32'h300; ld_byte = 1'b0;
      st_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         st_addr = 32'h20 + 32'(4 * k);
         st_data = 32'hB0 + 32'(k);
         #1;
         chk("t2_ld_we", 32'(mem_we), 32'd0);
         chk("t2_ld_a", mem_a, 32'h300);
         chk("t2_ld_data", ld_data, 32'hC0DE00C0);
         chk("t2_cnt", 32'(sb_count), 32'(k));
         tick();
      end
      st_addr = 32'h30; st_data = 32'hB4;
      #1;
      chk("t2_full_ready", 32'(st_ready), 32'd0);
      chk("t2_full_cnt", 32'(sb_count), 32'd4);
      tick();
      chk("t2_nopush_cnt", 32'(sb_count), 32'd4);
      ld_req = 1'b0;
      #1;
      chk("t2_resume_we", 32'(mem_we), 32'd1);
      chk("t2_resume_a", mem_a, 32'h20);
      chk("t2_resume_ready", 32'(st_ready), 32'd0);
      tick();
      chk("t2_reopen", 32'(st_ready), 32'd1);
      chk("t2_cnt3", 32'(sb_count), 32'd3);
      chk("t2_a24", mem_a, 32'h24);
      tick();
      st_valid = 1'b0;
      chk("t2_pushpop_cnt", 32'(sb_count), 32'd3);
      repeat (4) tick();
      chk("t2_empty", 32'(sb_empty), 32'd1);
      for (int k = 0; k < 5; k++)
         chk("t2_mem", dmem[8 + k], 32'hB0 + 32'(k));

      // word load hitting a just-pushed word store
      st_valid = 1'b1; st_byte = 1'b0; st_addr = 32'h40; st_data = 32'hDEADBEEF;
      #1;
      tick();
      st_valid = 1'b0;
      ld_req = 1'b1; ld_addr = 32'h40; ld_byte = 1'b0;
      #1;
      chk("t3_drain_we", 32'(mem_we), 32'd1);
      chk("t3_drain_a", mem_a, 32'h40);
`ifdef STBUF_FWD_EN
      chk("t3_fwd_stall", 32'(ld_stall), 32'd0);
      chk("t3_fwd_data", ld_data, 32'hDEADBEEF);
`else
      chk("t3_stall", 32'(ld_stall), 32'd1);
`endif
      tick();
      chk("t3_after_stall", 32'(ld_stall), 32'd0);
      chk("t3_after_data", ld_data, 32'hDEADBEEF);
      chk("t3_after_we", 32'(mem_we), 32'd0);
      ld_req = 1'b0;

      // byte store, byte loads to a different and the same lane
      st_valid = 1'b1; st_byte = 1'b1; st_addr = 32'h81; st_data = 32'h5A;
      #1;
      tick();
      st_valid = 1'b0; st_byte = 1'b0;
      ld_req = 1'b1; ld_byte = 1'b1; ld_addr = 32'h82;
      #1;
      chk("t4_lane_stall", 32'(ld_stall), 32'd1);
      chk("t4_drain_be", 32'(mem_be), 32'd1);
      chk("t4_drain_a", mem_a, 32'h81);
      tick();
      chk("t4_unstall", 32'(ld_stall), 32'd0);
      chk("t4_lane2", ld_data, 32'h000000DE);
      ld_addr = 32'h81;
      #1;
      chk("t4_lane1", ld_data, 32'h0000005A);
      ld_req = 1'b0;
      st_valid = 1'b1; st_byte = 1'b1; st_addr = 32'h81; st_data = 32'h77;
      #1;
      tick();
      st_valid = 1'b0; st_byte = 1'b0;
      ld_req = 1'b1; ld_byte = 1'b1; ld_addr = 32'h81;
      #1;
`ifdef STBUF_FWD_EN
      chk("t4_fwd_stall", 32'(ld_stall), 32'd0);
      chk("t4_fwd_data", ld_data, 32'h00000077);
`else
      chk("t4_same_stall", 32'(ld_stall), 32'd1);
`endif
      tick();
      chk("t4_same_data", ld_data, 32'h00000077);
      ld_byte = 1'b0; ld_addr = 32'h80;
      #1;
      chk("t4_word", ld_data, 32'hC0DE7720);
      ld_req = 1'b0;

      // reset with three entries queued discards them
      ld_req = 1'b1; ld_addr = 32'h300; ld_byte = 1'b0;
      st_valid = 1'b1; st_byte = 1'b0;
      for (int k = 0; k < 3; k++) begin
         st_addr = 32'h50 + 32'(4 * k);
         st_data = 32'h11 * 32'(k + 1);
         #1;
         tick();
      end
      st_valid = 1'b0;
      #1;
      chk("t6_queued", 32'(sb_count), 32'd3);
      reset_n = 1'b0;
      ld_req = 1'b0;
      #1;
      chk("t6_rst_we", 32'(mem_we), 32'd0);
      chk("t6_rst_cnt", 32'(sb_count), 32'd0);
      chk("t6_rst_empty", 32'(sb_empty), 32'd1);
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      chk("t6_post_we", 32'(mem_we), 32'd0);
      tick();
      tick();
      for (int k = 0; k < 3; k++)
         chk("t6_mem", dmem[20 + k], {16'hC0DE, 16'(20 + k)});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
